// File: rtl/sqrt_coeff_server.sv
// sqrt_coeff_server: dual coefficient tables for the square-root datapath.
// Both tables are read in parallel at one index with a two-stage pipeline
// (index register, then output register). A loader FSM fills one selected
// table with exactly 2**IDX_W words. Table contents are never reset.
// Optional feature macro: SQRT_COEFF_PARITY_EN adds a stored even-parity
// bit per entry and a parity_err output aligned with rd_valid.
module sqrt_coeff_server #(
  parameter int IDX_W   = 6,
  parameter int COEFF_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   x_f_A,
  input  logic               rd_en,
  output logic [COEFF_W-1:0] coeffs_Sqrt1_out,
  output logic [COEFF_W-1:0] coeffs_Sqrt2_out,
  output logic               rd_valid,
  input  logic               ld_start,
  input  logic               ld_sel,
  input  logic [COEFF_W-1:0] ld_data,
  input  logic               ld_valid,
  output logic               ld_busy,
  output logic               ld_done
`ifdef SQRT_COEFF_PARITY_EN
  ,
  output logic               parity_err
`endif
);

  localparam int DEPTH = 2**IDX_W;
`ifdef SQRT_COEFF_PARITY_EN
  localparam int ENT_W = COEFF_W + 1;
`else
  localparam int ENT_W = COEFF_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               sel_q, sel_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               v1_q, v1_d;
  logic               rd_valid_q, rd_valid_d;
  logic [COEFF_W-1:0] out1_q, out1_d;
  logic [COEFF_W-1:0] out2_q, out2_d;
  logic               we1, we2;
  logic [ENT_W-1:0]   wentry, rent1, rent2;

  logic [ENT_W-1:0]   tab1 [DEPTH];
  logic [ENT_W-1:0]   tab2 [DEPTH];

`ifdef SQRT_COEFF_PARITY_EN
  logic parity_err_q, parity_err_d;
  // Stored bit makes each entry even overall, so a nonzero XOR is an error.
  assign wentry = {^ld_data, ld_data};
  assign parity_err_d = v1_q & ((^rent1) | (^rent2));
  assign parity_err = parity_err_q;
`else
  assign wentry = ld_data;
`endif

  assign rent1 = tab1[idx_q];
  assign rent2 = tab2[idx_q];

  assign ld_busy          = (state_q != S_IDLE);
  assign ld_done          = (state_q == S_DONE);
  assign rd_valid         = rd_valid_q;
  assign coeffs_Sqrt1_out = out1_q;
  assign coeffs_Sqrt2_out = out2_q;

  // Loader next-state: latch select on start, write one word per ld_valid.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    we1     = 1'b0;
    we2     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          sel_d   = ld_sel;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          we1 = ~sel_q & ~rst;
          we2 =  sel_q & ~rst;
          if (cnt_q == {IDX_W{1'b1}}) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read pipeline next-state: reads are refused while a load is in progress.
  always_comb begin
    v1_d       = rd_en & ~ld_busy;
    idx_d      = v1_d ? x_f_A : idx_q;
    rd_valid_d = v1_q;
    out1_d     = v1_q ? rent1[COEFF_W-1:0] : out1_q;
    out2_d     = v1_q ? rent2[COEFF_W-1:0] : out2_q;
  end

  // Control and pipeline registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      idx_q        <= '0;
      v1_q         <= 1'b0;
      rd_valid_q   <= 1'b0;
      out1_q       <= '0;
      out2_q       <= '0;
`ifdef SQRT_COEFF_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      idx_q        <= idx_d;
      v1_q         <= v1_d;
      rd_valid_q   <= rd_valid_d;
      out1_q       <= out1_d;
      out2_q       <= out2_d;
`ifdef SQRT_COEFF_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Table storage: no reset, so an abandoned load keeps its written words.
  always_ff @(posedge clk) begin
    if (we1) tab1[cnt_q] <= wentry;
    if (we2) tab2[cnt_q] <= wentry;
  end

endmodule

// File: tb/tb_sqrt_coeff_server.sv
// Scoreboard bench for sqrt_coeff_server: stimulus pushes expected read
// words, a negedge monitor pops and compares whenever rd_valid is high and
// checks that outputs hold otherwise.
module tb_sqrt_coeff_server;
  localparam int IDX_W   = 6;
  localparam int COEFF_W = 32;
  localparam int DEPTH   = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic [IDX_W-1:0]   x_f_A;
  logic               rd_en;
  logic [COEFF_W-1:0] coeffs_Sqrt1_out, coeffs_Sqrt2_out;
  logic               rd_valid;
  logic               ld_start, ld_sel, ld_valid;
  logic [COEFF_W-1:0] ld_data;
  logic               ld_busy, ld_done;
`ifdef SQRT_COEFF_PARITY_EN
  logic               parity_err;
`endif

  sqrt_coeff_server #(.IDX_W(IDX_W), .COEFF_W(COEFF_W)) dut (
    .clk(clk), .rst(rst), .x_f_A(x_f_A), .rd_en(rd_en),
    .coeffs_Sqrt1_out(coeffs_Sqrt1_out), .coeffs_Sqrt2_out(coeffs_Sqrt2_out),
    .rd_valid(rd_valid), .ld_start(ld_start), .ld_sel(ld_sel),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_busy(ld_busy),
    .ld_done(ld_done)
`ifdef SQRT_COEFF_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] w1; logic [31:0] w2; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  logic [31:0] m1 [DEPTH];
  logic [31:0] m2 [DEPTH];
  logic [31:0] last1 = '0, last2 = '0;
  bit mon_en = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one read cycle; when accepted the expected pair is queued.
  task automatic rd(input int idx, input bit accept);
    x_f_A = idx[IDX_W-1:0];
    rd_en = 1'b1;
    if (accept) sb.push_back('{w1: m1[idx], w2: m2[idx]});
    tick();
    rd_en = 1'b0;
  endtask

  task automatic start_load(input logic sel);
    ld_start = 1'b1;
    ld_sel   = sel;
    tick();
    ld_start = 1'b0;
    chk("busy_after_start", {31'b0, ld_busy}, 32'd1);
  endtask

  task automatic send_word(input logic sel, input int i, input logic [31:0] w);
    ld_data  = w;
    ld_valid = 1'b1;
    if (sel) m2[i] = w; else m1[i] = w;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic check_done();
    chk("done_pulse", {31'b0, ld_done}, 32'd1);
    chk("busy_in_done", {31'b0, ld_busy}, 32'd1);
    tick();
    chk("done_cleared", {31'b0, ld_done}, 32'd0);
    chk("busy_cleared", {31'b0, ld_busy}, 32'd0);
  endtask

  // Monitor: compare on every valid read, otherwise outputs must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected actual=rd_valid=1 expected=rd_valid=0 at %0t", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_sqrt1", coeffs_Sqrt1_out, e.w1);
          chk("rd_sqrt2", coeffs_Sqrt2_out, e.w2);
`ifdef SQRT_COEFF_PARITY_EN
          chk("parity_err", {31'b0, parity_err}, 32'd0);
`endif
          last1 = e.w1;
          last2 = e.w2;
        end
      end else begin
        chk("hold_sqrt1", coeffs_Sqrt1_out, last1);
        chk("hold_sqrt2", coeffs_Sqrt2_out, last2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; x_f_A = '0; rd_en = 1'b0; ld_start = 1'b0; ld_sel = 1'b0;
    ld_data = '0; ld_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_busy", {31'b0, ld_busy}, 32'd0);
    chk("rst_done", {31'b0, ld_done}, 32'd0);
    chk("rst_out1", coeffs_Sqrt1_out, 32'd0);
    chk("rst_out2", coeffs_Sqrt2_out, 32'd0);
    mon_en = 1'b1;

    // Full contiguous load of table 1.
    start_load(1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      send_word(1'b0, i, 32'h0010_0000 + i);
      if (i == 62) begin
        chk("busy_mid_load", {31'b0, ld_busy}, 32'd1);
        chk("no_early_done", {31'b0, ld_done}, 32'd0);
      end
    end
    check_done();

    // Gapped load of table 2; reads and a stray ld_start in the gaps are ignored.
    start_load(1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      send_word(1'b1, i, 32'h0020_0000 + 32'(i * 7));
      if (i != DEPTH - 1) begin
        if (i == 20) begin
          ld_start = 1'b1;
          ld_sel   = 1'b0;
          tick();
          ld_start = 1'b0;
        end else if (i % 8 == 3) begin
          rd(i, 1'b0);
        end else begin
          tick();
        end
      end
    end
    check_done();

    // Stray ld_valid in IDLE must not write anything.
    ld_data = 32'hDEAD_BEEF;
    ld_valid = 1'b1;
    tick(); tick();
    ld_valid = 1'b0;

    // Single read then back-to-back reads at the table extremes.
    rd(5, 1'b1);
    tick(); tick();
    rd(0, 1'b1);
    rd(63, 1'b1);
    rd(17, 1'b1);
    tick(); tick(); tick();

    // Read accepted in the same cycle as ld_start returns pre-load contents.
    x_f_A = 6'd7;
    rd_en = 1'b1;
    sb.push_back('{w1: m1[7], w2: m2[7]});
    ld_start = 1'b1;
    ld_sel = 1'b0;
    tick();
    rd_en = 1'b0;
    ld_start = 1'b0;
    chk("busy_after_start_rd", {31'b0, ld_busy}, 32'd1);
    for (int i = 0; i < 10; i++) send_word(1'b0, i, 32'hABC0_0000 + i);

    // Reset mid-load: load abandoned, outputs cleared, written words kept.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last1 = '0;
    last2 = '0;
    chk("rst_mid_busy", {31'b0, ld_busy}, 32'd0);
    chk("rst_mid_done", {31'b0, ld_done}, 32'd0);
    chk("rst_mid_out1", coeffs_Sqrt1_out, 32'd0);
    for (int i = 0; i < 13; i++) rd(i, 1'b1);
    rd(63, 1'b1);
    tick(); tick(); tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sqrt_coeff_server.md
SQRT_COEFF_SERVER -- requirements
Module: sqrt_coeff_server

Interface
- REQ-001 SHALL have parameter IDX_W, default 6: index width; table depth is 2**IDX_W (64 entries).
- REQ-002 SHALL have parameter COEFF_W, default 32: coefficient word width ([31:20] slope, [19:0] offset).
- REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
- REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
- REQ-005 SHALL have port x_f_A  input  IDX_W  read index from the square-root datapath.
- REQ-006 SHALL have port rd_en  input  1  read request qualifier for x_f_A.
- REQ-007 SHALL have port coeffs_Sqrt1_out  output  COEFF_W  table-1 word (odd exponent).
- REQ-008 SHALL have port coeffs_Sqrt2_out  output  COEFF_W  table-2 word (even exponent).
- REQ-009 SHALL have port rd_valid  output  1  coefficient outputs valid this cycle.
- REQ-010 SHALL have port ld_start  input  1  one-cycle pulse that begins a table load.
- REQ-011 SHALL have port ld_sel  input  1  table select sampled with ld_start: 0 = Sqrt1, 1 = Sqrt2.
- REQ-012 SHALL have port ld_data  input  COEFF_W  load word.
- REQ-013 SHALL have port ld_valid  input  1  ld_data valid; one word accepted per asserted cycle.
- REQ-014 SHALL have port ld_busy  output  1  load in progress.
- REQ-015 SHALL have port ld_done  output  1  one-cycle pulse when the last word is written.

Function
- REQ-016 SHALL hold two 2**IDX_W x COEFF_W tables, both read in parallel at the same index.
- REQ-017 SHALL give a fixed read latency of 2 cycles: rd_en=1 at edge N -> rd_valid=1 and data at edge N+2 (index register, then output register).
- REQ-018 SHALL accept a read every cycle (fully pipelined); rd_valid follows rd_en delayed by 2.
- REQ-019 SHALL hold coeffs_*_out at their last value while rd_valid=0.
- REQ-020 SHALL implement the loader FSM IDLE -> LOAD -> DONE -> IDLE.
- REQ-021 IDLE: ld_start=1 latches ld_sel, clears the word counter, enters LOAD next cycle.
- REQ-022 LOAD: each ld_valid=1 cycle writes ld_data to the selected table at counter, then increments; the write of counter = 2**IDX_W-1 enters DONE.
- REQ-023 DONE: ld_done=1 for exactly one cycle, then IDLE.
- REQ-024 ld_busy SHALL be 1 in LOAD and DONE, else 0.
- REQ-025 SHALL ignore ld_start outside IDLE, and ld_valid outside LOAD.
- REQ-026 SHALL ignore rd_en while ld_busy=1 (no rd_valid generated); reads already in the pipeline complete normally.
- REQ-027 ld_start and rd_en in the same IDLE cycle: read accepted and completes with pre-load contents; load begins next cycle.
- REQ-028 Counter SHALL not wrap; exactly 2**IDX_W words per load.

Reset
- REQ-029 rst SHALL force FSM to IDLE, counter 0, rd_valid 0, pipeline valids 0, ld_busy 0, ld_done 0, coeffs_Sqrt1_out and coeffs_Sqrt2_out 0.
- REQ-030 Table contents SHALL NOT be reset; reset mid-load abandons the load, keeping words already written.
- REQ-031 rst SHALL take priority over all other inputs in the same cycle.

Configuration
- REQ-032 With SQRT_COEFF_PARITY_EN defined, each entry SHALL store an extra even-parity bit computed at write; output parity_err (1 bit) SHALL assert with rd_valid when either read word's stored parity mismatches its recomputed parity; reset 0.
- REQ-033 Without SQRT_COEFF_PARITY_EN, no parity storage and no parity_err port SHALL exist; all other behaviour is identical.

Verification
- REQ-034 Load Sqrt1 with word[i]=32'h0010_0000+i, i=0..63 -> ld_busy 1 from the cycle after ld_start, ld_done one pulse after 64th ld_valid, then ld_busy 0.
- REQ-035 After load, rd_en=1 with x_f_A=5 at edge N -> rd_valid=1 at N+2, coeffs_Sqrt1_out=32'h0010_0005.
- REQ-036 Back-to-back reads at indices 0,63,17 on consecutive cycles -> three consecutive rd_valid cycles with matching words in order.
- REQ-037 ld_valid gaps (every other cycle) during load -> exactly 64 words written, no skipped or duplicate index.
- REQ-038 rst after 10 load words -> ld_busy 0 next cycle, entries 0..9 hold new values, 10..63 old values.
- REQ-039 rd_en during LOAD -> rd_valid stays 0; with SQRT_COEFF_PARITY_EN, parity_err stays 0 on all normal reads.
